// File: rtl/kernel_bank.sv
// Convolution-kernel store: NUM_KERNELS signed SIZE x SIZE banks loaded over a
// valid/ready coefficient stream, with one registered active kernel switched on frame_start.
module kernel_bank #(
  parameter int SIZE         = 3,
  parameter int KERNEL_WIDTH = 8,
  parameter int NUM_KERNELS  = 4,
  localparam int SEL_W       = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int NC          = SIZE * SIZE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load_start,
  input  logic [SEL_W-1:0]           load_sel,
  input  logic                       load_abort,
  input  logic                       coef_valid,
  input  logic [KERNEL_WIDTH-1:0]    coef_data,
  output logic                       coef_ready,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_error,
  input  logic                       frame_start,
  input  logic [SEL_W-1:0]           active_sel,
  output logic [SEL_W-1:0]           active_idx,
  output logic [NC*KERNEL_WIDTH-1:0] kernel
);

  localparam int KW    = KERNEL_WIDTH;
  localparam int CNT_W = (NC > 1) ? $clog2(NC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  typedef logic [NC-1:0][KW-1:0] kern_t;

  // Reset contents: Sobel-Y, Sobel-X, identity, zeros for 3x3; identity otherwise.
  function automatic kern_t dflt_bank(input int b);
    kern_t k;
    int r, c, v;
    for (int i = 0; i < NC; i++) begin
      r = i / SIZE;
      c = i % SIZE;
      if (SIZE != 3) v = (i == NC / 2) ? 1 : 0;
      else begin
        case (b)
          0:       v = (r - 1) * ((c == 1) ? 2 : 1);
          1:       v = (c - 1) * ((r == 1) ? 2 : 1);
          2:       v = (i == NC / 2) ? 1 : 0;
          default: v = 0;
        endcase
      end
      k[i] = KW'(v);
    end
    return k;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             beat;
  logic             load_ok, act_ok;
  kern_t            staging_q;
  kern_t            kernel_q;
  logic [SEL_W-1:0] active_q;
  kern_t [NUM_KERNELS-1:0] bank_q;

  // A power-of-two bank count makes every select value legal.
  if ((1 << SEL_W) == NUM_KERNELS) begin : g_pow2
    assign load_ok = 1'b1;
    assign act_ok  = 1'b1;
  end else begin : g_npow2
    assign load_ok = load_sel < SEL_W'(NUM_KERNELS);
    assign act_ok  = active_sel < SEL_W'(NUM_KERNELS);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    beat    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (load_ok) begin
            sel_d   = load_sel;
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (coef_valid) begin
          beat  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NC - 1)) begin
            cnt_d   = '0;
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      staging_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (beat) staging_q[cnt_q] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_KERNELS; b++) bank_q[b] <= dflt_bank(b);
    end else if (state_q == S_COMMIT) begin
      bank_q[sel_q] <= staging_q;
    end
  end

  // The bank write lands on the same edge, so a same-bank switch forwards staging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      kernel_q <= dflt_bank(0);
    end else if (frame_start && act_ok) begin
      active_q <= active_sel;
      kernel_q <= (state_q == S_COMMIT && sel_q == active_sel) ? staging_q : bank_q[active_sel];
    end
  end

  assign coef_ready = (state_q == S_LOAD);
  assign load_busy  = (state_q == S_LOAD) || (state_q == S_COMMIT);
  assign load_done  = (state_q == S_COMMIT);
  assign load_error = err_q;
  assign active_idx = active_q;
  assign kernel     = kernel_q;

endmodule

// File: tb/tb_kernel_bank.sv
// Randomized self-checking bench for kernel_bank against a bank-array reference model.
module tb_kernel_bank;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        load_start = 0, load_abort = 0, coef_valid = 0, frame_start = 0;
  logic [1:0]  load_sel = 0, active_sel = 0, active_idx;
  logic [7:0]  coef_data = 0;
  logic        coef_ready, load_busy, load_done, load_error;
  logic [71:0] kernel;

  // Second instance with a non-power-of-two bank count exercises out-of-range selects.
  logic        e_load_start = 0, e_frame_start = 0;
  logic [1:0]  e_load_sel = 0, e_active_sel = 0, e_active_idx;
  logic        e_coef_ready, e_load_busy, e_load_done, e_load_error;
  logic [71:0] e_kernel;

  kernel_bank #(.SIZE(3), .KERNEL_WIDTH(8), .NUM_KERNELS(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_sel(load_sel),
    .load_abort(load_abort), .coef_valid(coef_valid), .coef_data(coef_data),
    .coef_ready(coef_ready), .load_busy(load_busy), .load_done(load_done),
    .load_error(load_error), .frame_start(frame_start), .active_sel(active_sel),
    .active_idx(active_idx), .kernel(kernel));

  kernel_bank #(.SIZE(3), .KERNEL_WIDTH(8), .NUM_KERNELS(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .load_start(e_load_start), .load_sel(e_load_sel),
    .load_abort(1'b0), .coef_valid(1'b0), .coef_data(8'h00),
    .coef_ready(e_coef_ready), .load_busy(e_load_busy), .load_done(e_load_done),
    .load_error(e_load_error), .frame_start(e_frame_start), .active_sel(e_active_sel),
    .active_idx(e_active_idx), .kernel(e_kernel));

  int n_chk = 0, n_pass = 0;
  int SY[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  int SX[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int ID[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  int bank_m[4][9];
  int kern_m[9];
  int idx_m;
  int ld_data[9];

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [71:0] pk(input int m[9]);
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(m[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 9; i++)
        bank_m[b][i] = (b == 0) ? SY[i] : (b == 1) ? SX[i] : (b == 2) ? ID[i] : 0;
    kern_m = SY;
    idx_m  = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_kernel"}, kernel, pk(kern_m));
    chk({tag, "_idx"}, {70'b0, active_idx}, 72'(idx_m));
  endtask

  task automatic do_frame(input int s);
    frame_start = 1; active_sel = 2'(s);
    tick();
    frame_start = 0;
    kern_m = bank_m[s];
    idx_m  = s;
    check_out("frame");
  endtask

  // Loads ld_data into bank b; gap_at<0, abort_at<0, fs<0 disable those features.
  task automatic do_load(input int b, input int gap_at, input int gap_len,
                         input int abort_at, input bit abort_beat, input int fs);
    load_start = 1; load_sel = 2'(b);
    tick();
    load_start = 0;
    chk("start_ready", coef_ready, 1);
    chk("start_busy", load_busy, 1);
    chk("start_noerr", load_error, 0);
    for (int i = 0; i < 9; i++) begin
      if (i == abort_at) begin
        load_abort = 1; coef_valid = abort_beat; coef_data = 8'(ld_data[i]);
        tick();
        load_abort = 0; coef_valid = 0;
        chk("abort_ready", coef_ready, 0);
        chk("abort_busy", load_busy, 0);
        chk("abort_done", load_done, 0);
        tick();
        chk("abort_done2", load_done, 0);
        check_out("abort");
        return;
      end
      coef_valid = 1; coef_data = 8'(ld_data[i]);
      tick();
      coef_valid = 0;
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          chk("gap_ready", coef_ready, 1);
          chk("gap_done", load_done, 0);
          load_start = 1; load_sel = 2'(b ^ 1);
          tick();
          load_start = 0;
          chk("gap_noerr", load_error, 0);
        end
      end
    end
    chk("commit_done", load_done, 1);
    chk("commit_ready", coef_ready, 0);
    chk("commit_busy", load_busy, 1);
    if (fs >= 0) begin frame_start = 1; active_sel = 2'(fs); end
    tick();
    frame_start = 0;
    for (int i = 0; i < 9; i++) bank_m[b][i] = ld_data[i];
    if (fs >= 0) begin kern_m = bank_m[fs]; idx_m = fs; end
    chk("post_done", load_done, 0);
    chk("post_busy", load_busy, 0);
    check_out("post_commit");
  endtask

  initial begin
    model_reset();
    #2 reset_n = 0;
    #1;
    check_out("reset");
    chk("reset_ready", coef_ready, 0);
    chk("reset_busy", load_busy, 0);
    chk("reset_done", load_done, 0);
    chk("reset_err", load_error, 0);
    #20;
    @(negedge clk) reset_n = 1;
    tick();
    check_out("post_reset");
    do_frame(1);

    // Bank 3 <- 1..9 with a 2-cycle gap after beat 4; active kernel must not move.
    for (int i = 0; i < 9; i++) ld_data[i] = i + 1;
    do_load(3, 3, 2, -1, 0, -1);
    do_frame(3);

    // Aborted load of bank 0 leaves Sobel-Y intact.
    for (int i = 0; i < 9; i++) ld_data[i] = 7;
    do_load(0, -1, 0, 5, 0, -1);
    do_frame(0);

    // Out-of-range selects on the 3-bank instance.
    e_load_start = 1; e_load_sel = 2'd3;
    tick();
    e_load_start = 0;
    chk("e_err_pulse", e_load_error, 1);
    chk("e_err_ready", e_coef_ready, 0);
    chk("e_err_busy", e_load_busy, 0);
    tick();
    chk("e_err_clear", e_load_error, 0);
    chk("e_err_done", e_load_done, 0);
    e_frame_start = 1; e_active_sel = 2'd1;
    tick();
    e_frame_start = 0;
    chk("e_frame1_idx", {70'b0, e_active_idx}, 72'd1);
    chk("e_frame1_kern", e_kernel, pk(SX));
    e_frame_start = 1; e_active_sel = 2'd3;
    tick();
    e_frame_start = 0;
    chk("e_frame3_idx", {70'b0, e_active_idx}, 72'd1);
    chk("e_frame3_kern", e_kernel, pk(SX));

    // -128 into bank 2 with frame_start on the commit cycle (forwarding).
    for (int i = 0; i < 9; i++) ld_data[i] = -128;
    do_load(2, -1, 0, -1, 0, 2);
    // Commit into the active bank without a frame_start holds the kernel.
    for (int i = 0; i < 9; i++) ld_data[i] = 3 * i - 10;
    do_load(2, 1, 1, -1, 0, -1);
    do_frame(2);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_frame($urandom_range(0, 3));
      end else begin
        int gap_at, abort_at, fs;
        for (int i = 0; i < 9; i++) ld_data[i] = $urandom_range(0, 255) - 128;
        gap_at   = $urandom_range(0, 9);
        if (gap_at > 7) gap_at = -1;
        abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
        fs       = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : -1;
        do_load($urandom_range(0, 3), gap_at, $urandom_range(1, 3), abort_at,
                1'($urandom_range(0, 1)), fs);
      end
    end

    // Asynchronous reset mid-load restores every default immediately.
    do_frame(1);
    load_start = 1; load_sel = 2'd2;
    tick();
    load_start = 0;
    for (int i = 0; i < 4; i++) begin
      coef_valid = 1; coef_data = 8'd55;
      tick();
    end
    coef_valid = 0;
    #3 reset_n = 0;
    #1;
    model_reset();
    check_out("async_rst");
    chk("async_rst_ready", coef_ready, 0);
    chk("async_rst_busy", load_busy, 0);
    #12;
    @(negedge clk) reset_n = 1;
    tick();
    for (int i = 0; i < 9; i++) ld_data[i] = 0;
    do_load(1, -1, 0, -1, 0, -1);
    do_frame(1);
    do_frame(2);
    do_frame(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
